// File: rtl/math_result_fifo_pkg.sv
// rtl/math_result_fifo_pkg.sv - sizing helpers and shared types for the math result fifo
package math_result_fifo_pkg;

  localparam int DEPTH_DEF = 8;

  // Depth must be a power of two so the pointers can wrap naturally.
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the level can hold DEPTH itself.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W = ptr_width(DEPTH_DEF);
  localparam int LVL_W = level_width(DEPTH_DEF);

  typedef logic [LVL_W-1:0] level_t;

endpackage

// File: rtl/math_computer_output_itf.sv
// rtl/math_computer_output_itf.sv - result handshake between the math core and its consumers
`ifndef DATASIZE
`define DATASIZE 32
`endif

interface math_computer_output_itf;
  logic [`DATASIZE-1:0] result;
  logic                 valid;
  logic                 ready;

  modport master (output result, output valid, input ready);
  modport slave  (input result, input valid, output ready);
endinterface

// File: rtl/math_fifo_mem.sv
// rtl/math_fifo_mem.sv - DEPTH x WIDTH storage, one write port, one asynchronous read port
module math_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; occupancy tracking decides what is meaningful.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/math_result_fifo.sv
// rtl/math_result_fifo.sv - first-word-fall-through result buffer behind the math core
`ifndef DATASIZE
`define DATASIZE 32
`endif

module math_result_fifo
  import math_result_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  math_computer_output_itf.slave     res_in,
  math_computer_output_itf.master    res_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     peak_level,
  output logic [31:0]                total_count
);

  localparam int DW = `DATASIZE;
  localparam int PW = ptr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("math_result_fifo: DEPTH must be a power of two >= 2");
  end

  logic          ready_en_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] peak_q, peak_d;
  logic [31:0]   total_q;
  logic          in_ready, push, pop;
  logic [DW-1:0] head;

  // Ready depends only on registered state, never on the consumer's ready.
  assign in_ready       = ready_en_q && (level_q != LW'(DEPTH));
  assign push           = res_in.valid && in_ready;
  assign pop            = res_out.valid && res_out.ready;
  assign res_in.ready   = in_ready;
  assign res_out.valid  = (level_q != '0);
  assign res_out.result = head;
  assign level          = level_q;
  assign peak_level     = peak_q;
  assign total_count    = total_q;

  math_fifo_mem #(.DEPTH(DEPTH), .WIDTH(DW)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (res_in.result),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Next occupancy and high-water mark.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    peak_d = (level_d > peak_q) ? level_d : peak_q;
  end

  // Pointer, occupancy and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      peak_q     <= '0;
      total_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        total_q  <= total_q + 32'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      peak_q  <= peak_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (level_q == LW'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (level_q == '0)));
  a_level_range: assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= LW'(DEPTH));
  a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (res_in.valid && !res_in.ready) |=> $stable(res_in.result));

endmodule

// File: tb/tb_math_result_fifo.sv
// tb/tb_math_result_fifo.sv - self-checking bench for math_result_fifo
`ifndef DATASIZE
`define DATASIZE 32
`endif

module tb_math_result_fifo;
  import math_result_fifo_pkg::*;

  localparam int W = `DATASIZE;
  localparam int D = DEPTH_DEF;
  localparam int NRAND = 3 * D + 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  math_computer_output_itf res_in_if ();
  math_computer_output_itf res_out_if ();
  level_t      level, peak_level;
  logic [31:0] total_count;

  math_result_fifo #(.DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_in      (res_in_if),
    .res_out     (res_out_if),
    .level       (level),
    .peak_level  (peak_level),
    .total_count (total_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of outstanding results plus simple counters.
  logic [W-1:0] m_q[$];
  bit           m_en;
  int           m_peak;
  int unsigned  m_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_en    = 1'b0;
    m_peak  = 0;
    m_total = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'b0, res_out_if.valid}, {31'b0, m_q.size() != 0});
    chk("in_ready", {31'b0, res_in_if.ready}, {31'b0, m_en && (m_q.size() < D)});
    chk("level", 32'(level), 32'(m_q.size()));
    chk("peak_level", 32'(peak_level), 32'(m_peak));
    chk("total_count", total_count, m_total);
    if (m_q.size() != 0) chk("out_result", res_out_if.result, m_q[0]);
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                      output bit pushed, output bit popped);
    res_in_if.valid  = v;
    res_in_if.result = d;
    res_out_if.ready = r;
    @(negedge clk);
    check_outputs();
    pushed = v && m_en && (m_q.size() < D);
    popped = (m_q.size() != 0) && r;
    @(posedge clk);
    if (popped) void'(m_q.pop_front());
    if (pushed) begin
      m_q.push_back(d);
      m_total++;
    end
    if (m_q.size() > m_peak) m_peak = m_q.size();
    m_en = 1'b1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    bit           pu, po;
    int unsigned  t0;
    logic [W-1:0] held, pend_d;
    bit           pend_v, r;
    int           sent, recv, max_seen, guard;

    rst_n = 1'b0;
    res_in_if.valid  = 1'b0;
    res_in_if.result = '0;
    res_out_if.ready = 1'b0;
    model_reset();

    // Reset state, then ready rises one edge after release.
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    step(0, '0, 0, pu, po);
    step(0, '0, 0, pu, po);
    chk("ready_after_release", {31'b0, res_in_if.ready}, 32'd1);

    // Fill to DEPTH with the consumer stalled, then drain in order.
    for (int i = 0; i < D; i++) step(1, W'(32'h11 + i), 0, pu, po);
    step(0, '0, 0, pu, po);
    chk("fill_level", 32'(level), 32'(D));
    chk("fill_peak", 32'(peak_level), 32'(D));
    chk("fill_total", total_count, 32'(D));
    chk("fill_ready", {31'b0, res_in_if.ready}, 32'd0);
    for (int i = 0; i < D; i++) begin
      chk("drain_data", res_out_if.result, 32'h11 + i);
      step(0, '0, 1, pu, po);
    end
    step(0, '0, 0, pu, po);
    chk("drain_valid", {31'b0, res_out_if.valid}, 32'd0);

    // Simultaneous push and pop at a steady level of 3.
    for (int i = 0; i < 3; i++) step(1, W'(32'h31 + i), 0, pu, po);
    t0 = total_count;
    for (int i = 0; i < 20; i++) step(1, W'($urandom), 1, pu, po);
    chk("simul_level", 32'(level), 32'd3);
    chk("simul_total", total_count, t0 + 32'd20);

    // Full with a pop in the same cycle: no push until the slot is free.
    for (int i = 0; i < D - 3; i++) step(1, W'($urandom), 0, pu, po);
    chk("full_level", 32'(level), 32'(D));
    step(1, W'(32'hA5), 1, pu, po);
    chk("full_pop_no_push", {31'b0, pu}, 32'd0);
    chk("full_pop_level", 32'(level), 32'(D - 1));
    step(1, W'(32'hA5), 0, pu, po);
    chk("refill_level", 32'(level), 32'(D));

    // Back-pressure: head must stay put while the consumer stalls.
    held = res_out_if.result;
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 0, pu, po);
      chk("hold_result", res_out_if.result, held);
    end
    for (int i = 0; i < D; i++) step(0, '0, 1, pu, po);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) step(1, W'($urandom), 0, pu, po);
    res_in_if.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", {31'b0, res_out_if.valid}, 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    step(0, '0, 0, pu, po);
    step(0, '0, 0, pu, po);

    // Randomised traffic long enough to wrap the pointers several times.
    pend_v = 1'b0; pend_d = '0;
    sent = 0; recv = 0; max_seen = 0; guard = 0;
    while (recv < NRAND && guard < 2000) begin
      if (!pend_v && sent < NRAND && $urandom_range(0, 3) != 0) begin
        pend_v = 1'b1;
        pend_d = W'($urandom);
        sent++;
      end
      r = (guard < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(pend_v, pend_d, r, pu, po);
      if (pu) pend_v = 1'b0;
      if (po) recv++;
      if (m_q.size() > max_seen) max_seen = m_q.size();
      guard++;
    end
    chk("rand_all_received", 32'(recv), 32'(NRAND));
    chk("rand_peak", 32'(peak_level), 32'(max_seen));
    chk("rand_total", total_count, 32'(NRAND));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
